snoop_bus_ctrl: RTL and testbench

Shared snooping-bus controller sitting directly downstream of the per-processor `Cache` blocks. It collects their miss and writeback requests (`RdMs`/`WrMs`/`WrBk`) and arbitrates round-robin. It broadcasts the winning transaction to all caches for snooping, sources data from a dirty owner or from memory, and returns the line plus a shared indication to the requester.

---
 rtl/snoop_bus_pkg.sv | 22 ++
 rtl/rr_arbiter.sv | 34 +++
 rtl/snoop_bus_ctrl.sv | 259 +++++++++++++++++++++++++
 tb/tb_snoop_bus_ctrl.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/snoop_bus_pkg.sv
// Shared types and constants for the snooping-bus controller and its arbiter.
package snoop_bus_pkg;

  localparam int ID_W = 2;

  typedef enum logic [1:0] {
    OP_NONE = 2'd0,
    OP_RDMS = 2'd1,
    OP_WRMS = 2'd2,
    OP_WRBK = 2'd3
  } bus_op_t;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_BCAST = 3'd1,
    ST_SNOOP = 3'd2,
    ST_FLUSH = 3'd3,
    ST_MEM   = 3'd4,
    ST_RESP  = 3'd5
  } bus_state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: search begins one past the last winner.
module rr_arbiter
  import snoop_bus_pkg::*;
#(
  parameter int NUM_PROC = 4
) (
  input  logic [NUM_PROC-1:0] req,
  input  logic [ID_W-1:0]     last_grant,
  output logic [NUM_PROC-1:0] gnt_oh,
  output logic [ID_W-1:0]     gnt_idx,
  output logic                gnt_valid
);

  int              cand;
  logic [ID_W-1:0] cand_idx;

  always_comb begin
    gnt_oh    = '0;
    gnt_idx   = '0;
    gnt_valid = 1'b0;
    cand      = 0;
    cand_idx  = '0;
    for (int i = 1; i <= NUM_PROC; i++) begin
      cand     = (int'(last_grant) + i) % NUM_PROC;
      cand_idx = ID_W'(cand);
      if (!gnt_valid && req[cand_idx]) begin
        gnt_valid = 1'b1;
        gnt_idx   = cand_idx;
        gnt_oh    = NUM_PROC'(1) << cand_idx;
      end
    end
  end

endmodule

// File: rtl/snoop_bus_ctrl.sv
// Snooping-bus controller: arbitrates cache misses/writebacks, broadcasts them,
// sources data from a dirty owner or memory and returns it to the requester.
//
// state | meaning
// IDLE  | arbitrate among requesting caches, latch the winner
// BCAST | drive bus broadcast for one cycle
// SNOOP | sample masked snoop responses, pick dirty owner if any
// FLUSH | stage owner writeback to memory
// MEM   | hold memReq until memAck
// RESP  | one-cycle response strobe, release grant
module snoop_bus_ctrl
  import snoop_bus_pkg::*;
#(
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32,
  parameter int NUM_PROC = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [NUM_PROC-1:0]        reqRdMs,
  input  logic [NUM_PROC-1:0]        reqWrMs,
  input  logic [NUM_PROC-1:0]        reqWrBk,
  input  logic [NUM_PROC*ADDR_W-1:0] reqAddress,
  input  logic [NUM_PROC*DATA_W-1:0] reqValue,
  output logic [NUM_PROC-1:0]        grant,
  output logic                       busValid,
  output logic [1:0]                 busOp,
  output logic [ADDR_W-1:0]          busAddress,
  output logic [ID_W-1:0]            busProc_ID,
  input  logic [NUM_PROC-1:0]        snoopShared,
  input  logic [NUM_PROC-1:0]        snoopDirty,
  input  logic [NUM_PROC*DATA_W-1:0] snoopValue,
  output logic                       memReq,
  output logic                       memWe,
  output logic [ADDR_W-1:0]          memAddress,
  output logic [DATA_W-1:0]          memWData,
  input  logic                       memAck,
  input  logic [DATA_W-1:0]          memRData,
  output logic                       respValid,
  output logic [ID_W-1:0]            respProc_ID,
  output logic [DATA_W-1:0]          respValue,
  output logic                       respShared
);

  bus_state_t          state_q, state_d;
  logic [ID_W-1:0]     last_grant_q, last_grant_d;
  bus_op_t             op_q, op_d;
  logic [ID_W-1:0]     id_q, id_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [DATA_W-1:0]   data_q, data_d;
  logic                shared_q, shared_d;

  logic [NUM_PROC-1:0] grant_q, grant_d;
  logic                bus_valid_q, bus_valid_d;
  bus_op_t             bus_op_q, bus_op_d;
  logic [ADDR_W-1:0]   bus_addr_q, bus_addr_d;
  logic [ID_W-1:0]     bus_id_q, bus_id_d;
  logic                mem_req_q, mem_req_d;
  logic                mem_we_q, mem_we_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
  logic                resp_valid_q, resp_valid_d;
  logic [ID_W-1:0]     resp_id_q, resp_id_d;
  logic [DATA_W-1:0]   resp_value_q, resp_value_d;
  logic                resp_shared_q, resp_shared_d;

  logic [NUM_PROC-1:0] req_any;
  logic [NUM_PROC-1:0] win_oh;
  logic [ID_W-1:0]     win_idx;
  logic                win_valid;
  bus_op_t             win_op;
  logic [NUM_PROC-1:0] dirty_mask;
  logic [DATA_W-1:0]   dirty_val;

  assign req_any = reqRdMs | reqWrMs | reqWrBk;

  rr_arbiter #(.NUM_PROC(NUM_PROC)) u_arb (
    .req       (req_any),
    .last_grant(last_grant_q),
    .gnt_oh    (win_oh),
    .gnt_idx   (win_idx),
    .gnt_valid (win_valid)
  );

  always_comb begin
    win_op = OP_RDMS;
    if (reqWrBk[win_idx])      win_op = OP_WRBK;
    else if (reqWrMs[win_idx]) win_op = OP_WRMS;
  end

  // The requester never snoops its own transaction.
  assign dirty_mask = snoopDirty & ~grant_q;

  always_comb begin
    dirty_val = '0;
    for (int p = NUM_PROC - 1; p >= 0; p--) begin
      if (dirty_mask[p]) dirty_val = snoopValue[p*DATA_W +: DATA_W];
    end
  end

  always_comb begin
    state_d       = state_q;
    last_grant_d  = last_grant_q;
    op_d          = op_q;
    id_d          = id_q;
    addr_d        = addr_q;
    wdata_d       = wdata_q;
    data_d        = data_q;
    shared_d      = shared_q;
    grant_d       = grant_q;
    mem_req_d     = mem_req_q;
    mem_we_d      = mem_we_q;
    mem_addr_d    = mem_addr_q;
    mem_wdata_d   = mem_wdata_q;
    bus_valid_d   = 1'b0;
    bus_op_d      = OP_NONE;
    bus_addr_d    = '0;
    bus_id_d      = '0;
    resp_valid_d  = 1'b0;
    resp_id_d     = '0;
    resp_value_d  = '0;
    resp_shared_d = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (win_valid) begin
          state_d      = ST_BCAST;
          last_grant_d = win_idx;
          grant_d      = win_oh;
          op_d         = win_op;
          id_d         = win_idx;
          addr_d       = reqAddress[int'(win_idx)*ADDR_W +: ADDR_W];
          wdata_d      = reqValue[int'(win_idx)*DATA_W +: DATA_W];
          data_d       = '0;
          shared_d     = 1'b0;
          bus_valid_d  = 1'b1;
          bus_op_d     = win_op;
          bus_addr_d   = reqAddress[int'(win_idx)*ADDR_W +: ADDR_W];
          bus_id_d     = win_idx;
        end
      end
      ST_BCAST: begin
        if (op_q == OP_WRBK) begin
          state_d     = ST_MEM;
          mem_req_d   = 1'b1;
          mem_we_d    = 1'b1;
          mem_addr_d  = addr_q;
          mem_wdata_d = wdata_q;
        end else begin
          state_d = ST_SNOOP;
        end
      end
      ST_SNOOP: begin
        shared_d = |(snoopShared & ~grant_q);
        if (|dirty_mask) begin
          state_d = ST_FLUSH;
          data_d  = dirty_val;
        end else begin
          state_d    = ST_MEM;
          mem_req_d  = 1'b1;
          mem_we_d   = 1'b0;
          mem_addr_d = addr_q;
        end
      end
      ST_FLUSH: begin
        state_d     = ST_MEM;
        mem_req_d   = 1'b1;
        mem_we_d    = 1'b1;
        mem_addr_d  = addr_q;
        mem_wdata_d = data_q;
      end
      ST_MEM: begin
        if (mem_req_q && memAck) begin
          state_d       = ST_RESP;
          mem_req_d     = 1'b0;
          mem_we_d      = 1'b0;
          mem_addr_d    = '0;
          mem_wdata_d   = '0;
          if (!mem_we_q) data_d = memRData;
          resp_valid_d  = 1'b1;
          resp_id_d     = id_q;
          resp_value_d  = (op_q == OP_WRBK) ? '0 : (mem_we_q ? data_q : memRData);
          resp_shared_d = (op_q == OP_RDMS) ? shared_q : 1'b0;
        end
      end
      ST_RESP: begin
        state_d = ST_IDLE;
        grant_d = '0;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      last_grant_q  <= ID_W'(NUM_PROC - 1);
      op_q          <= OP_NONE;
      id_q          <= '0;
      addr_q        <= '0;
      wdata_q       <= '0;
      data_q        <= '0;
      shared_q      <= 1'b0;
      grant_q       <= '0;
      bus_valid_q   <= 1'b0;
      bus_op_q      <= OP_NONE;
      bus_addr_q    <= '0;
      bus_id_q      <= '0;
      mem_req_q     <= 1'b0;
      mem_we_q      <= 1'b0;
      mem_addr_q    <= '0;
      mem_wdata_q   <= '0;
      resp_valid_q  <= 1'b0;
      resp_id_q     <= '0;
      resp_value_q  <= '0;
      resp_shared_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      last_grant_q  <= last_grant_d;
      op_q          <= op_d;
      id_q          <= id_d;
      addr_q        <= addr_d;
      wdata_q       <= wdata_d;
      data_q        <= data_d;
      shared_q      <= shared_d;
      grant_q       <= grant_d;
      bus_valid_q   <= bus_valid_d;
      bus_op_q      <= bus_op_d;
      bus_addr_q    <= bus_addr_d;
      bus_id_q      <= bus_id_d;
      mem_req_q     <= mem_req_d;
      mem_we_q      <= mem_we_d;
      mem_addr_q    <= mem_addr_d;
      mem_wdata_q   <= mem_wdata_d;
      resp_valid_q  <= resp_valid_d;
      resp_id_q     <= resp_id_d;
      resp_value_q  <= resp_value_d;
      resp_shared_q <= resp_shared_d;
    end
  end

  assign grant       = grant_q;
  assign busValid    = bus_valid_q;
  assign busOp       = bus_op_q;
  assign busAddress  = bus_addr_q;
  assign busProc_ID  = bus_id_q;
  assign memReq      = mem_req_q;
  assign memWe       = mem_we_q;
  assign memAddress  = mem_addr_q;
  assign memWData    = mem_wdata_q;
  assign respValid   = resp_valid_q;
  assign respProc_ID = resp_id_q;
  assign respValue   = resp_value_q;
  assign respShared  = resp_shared_q;

endmodule

// File: tb/tb_snoop_bus_ctrl.sv
// Directed bench for snoop_bus_ctrl: reset, clean/dirty/writeback flows, fairness, stall and mid-op reset.
module tb_snoop_bus_ctrl;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int NP     = 4;

  logic               clk;
  logic               rst_n;
  logic [NP-1:0]      reqRdMs, reqWrMs, reqWrBk;
  logic [NP*ADDR_W-1:0] reqAddress;
  logic [NP*DATA_W-1:0] reqValue;
  logic [NP-1:0]      grant;
  logic               busValid;
  logic [1:0]         busOp;
  logic [ADDR_W-1:0]  busAddress;
  logic [1:0]         busProc_ID;
  logic [NP-1:0]      snoopShared, snoopDirty;
  logic [NP*DATA_W-1:0] snoopValue;
  logic               memReq, memWe;
  logic [ADDR_W-1:0]  memAddress;
  logic [DATA_W-1:0]  memWData;
  logic               memAck;
  logic [DATA_W-1:0]  memRData;
  logic               respValid;
  logic [1:0]         respProc_ID;
  logic [DATA_W-1:0]  respValue;
  logic               respShared;

  int n_checks = 0;
  int n_fail   = 0;

  snoop_bus_ctrl #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .NUM_PROC(NP)) dut (
    .clk(clk), .rst_n(rst_n),
    .reqRdMs(reqRdMs), .reqWrMs(reqWrMs), .reqWrBk(reqWrBk),
    .reqAddress(reqAddress), .reqValue(reqValue),
    .grant(grant), .busValid(busValid), .busOp(busOp),
    .busAddress(busAddress), .busProc_ID(busProc_ID),
    .snoopShared(snoopShared), .snoopDirty(snoopDirty), .snoopValue(snoopValue),
    .memReq(memReq), .memWe(memWe), .memAddress(memAddress), .memWData(memWData),
    .memAck(memAck), .memRData(memRData),
    .respValid(respValid), .respProc_ID(respProc_ID),
    .respValue(respValue), .respShared(respShared)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    reqRdMs = '0; reqWrMs = '0; reqWrBk = '0;
    reqAddress = '0; reqValue = '0;
    snoopShared = '0; snoopDirty = '0; snoopValue = '0;
    memAck = 1'b0; memRData = '0;
  endtask

  task automatic test_reset();
    clear_inputs();
    rst_n = 1'b0;
    reqRdMs = 4'hF;
    reqAddress[0 +: ADDR_W] = 32'h100;
    memAck = 1'b1;
    step();
    step();
    n_checks++;
    if (grant !== 4'b0000) begin n_fail++; $display("FAIL reset_grant: got %b want 0000", grant); end
    n_checks++;
    if ({busValid, busOp, busAddress, busProc_ID} !== '0) begin
      n_fail++; $display("FAIL reset_bus: valid=%b op=%0d addr=%h id=%0d want all 0", busValid, busOp, busAddress, busProc_ID);
    end
    n_checks++;
    if ({memReq, memWe, memAddress, memWData} !== '0) begin
      n_fail++; $display("FAIL reset_mem: req=%b we=%b addr=%h wdata=%h want all 0", memReq, memWe, memAddress, memWData);
    end
    n_checks++;
    if ({respValid, respProc_ID, respValue, respShared} !== '0) begin
      n_fail++; $display("FAIL reset_resp: valid=%b id=%0d value=%h shared=%b want all 0", respValid, respProc_ID, respValue, respShared);
    end
    clear_inputs();
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_clean_rdms();
    reqRdMs[2] = 1'b1;
    reqAddress[2*ADDR_W +: ADDR_W] = 32'h4;
    snoopShared = 4'b0010;
    step(); // BCAST
    n_checks++;
    if ({busValid, busOp, busProc_ID} !== {1'b1, 2'd1, 2'd2}) begin
      n_fail++; $display("FAIL clean_bcast: valid=%b op=%0d id=%0d want 1/1/2", busValid, busOp, busProc_ID);
    end
    n_checks++;
    if (busAddress !== 32'h4 || grant !== 4'b0100) begin
      n_fail++; $display("FAIL clean_bcast_addr: addr=%h grant=%b want 4/0100", busAddress, grant);
    end
    step(); // SNOOP
    n_checks++;
    if (busValid !== 1'b0 || memReq !== 1'b0) begin
      n_fail++; $display("FAIL clean_snoop: busValid=%b memReq=%b want 0/0", busValid, memReq);
    end
    step(); // MEM
    n_checks++;
    if ({memReq, memWe, memAddress} !== {1'b1, 1'b0, 32'h4}) begin
      n_fail++; $display("FAIL clean_mem: req=%b we=%b addr=%h want 1/0/4", memReq, memWe, memAddress);
    end
    memAck = 1'b1; memRData = 32'h5;
    step(); // RESP
    memAck = 1'b0; memRData = '0;
    reqRdMs = '0;
    n_checks++;
    if ({respValid, respValue, respShared, respProc_ID} !== {1'b1, 32'h5, 1'b1, 2'd2}) begin
      n_fail++; $display("FAIL clean_resp: valid=%b value=%h shared=%b id=%0d want 1/5/1/2", respValid, respValue, respShared, respProc_ID);
    end
    n_checks++;
    if (memReq !== 1'b0 || grant !== 4'b0100) begin
      n_fail++; $display("FAIL clean_resp_side: memReq=%b grant=%b want 0/0100", memReq, grant);
    end
    step(); // IDLE
    n_checks++;
    if (respValid !== 1'b0 || grant !== 4'b0000) begin
      n_fail++; $display("FAIL clean_release: respValid=%b grant=%b want 0/0000", respValid, grant);
    end
    clear_inputs();
  endtask

  task automatic test_dirty_intervention();
    reqWrMs[0] = 1'b1;
    reqAddress[0 +: ADDR_W] = 32'h8;
    snoopDirty  = 4'b1001;              // bit 0 is the requester and must be ignored
    snoopShared = 4'b1000;
    snoopValue[0 +: DATA_W]        = 32'h55;
    snoopValue[3*DATA_W +: DATA_W] = 32'hAA;
    step(); // BCAST
    n_checks++;
    if ({busValid, busOp, busProc_ID, grant} !== {1'b1, 2'd2, 2'd0, 4'b0001}) begin
      n_fail++; $display("FAIL dirty_bcast: valid=%b op=%0d id=%0d grant=%b want 1/2/0/0001", busValid, busOp, busProc_ID, grant);
    end
    step(); // SNOOP
    step(); // FLUSH
    n_checks++;
    if (memReq !== 1'b0 || respValid !== 1'b0) begin
      n_fail++; $display("FAIL dirty_flush: memReq=%b respValid=%b want 0/0", memReq, respValid);
    end
    step(); // MEM write
    n_checks++;
    if ({memReq, memWe, memAddress, memWData} !== {1'b1, 1'b1, 32'h8, 32'hAA}) begin
      n_fail++; $display("FAIL dirty_mem: req=%b we=%b addr=%h wdata=%h want 1/1/8/aa", memReq, memWe, memAddress, memWData);
    end
    memAck = 1'b1; memRData = 32'h33;
    step(); // RESP at cycle 5
    memAck = 1'b0; reqWrMs = '0;
    n_checks++;
    if ({respValid, respValue, respShared, respProc_ID} !== {1'b1, 32'hAA, 1'b0, 2'd0}) begin
      n_fail++; $display("FAIL dirty_resp: valid=%b value=%h shared=%b id=%0d want 1/aa/0/0", respValid, respValue, respShared, respProc_ID);
    end
    step();
    clear_inputs();
  endtask

  task automatic test_wrbk();
    reqWrBk[1] = 1'b1;
    reqRdMs[1] = 1'b1;                  // WrBk outranks RdMs on the same cache
    reqAddress[1*ADDR_W +: ADDR_W] = 32'h10;
    reqValue[1*DATA_W +: DATA_W]   = 32'h7;
    snoopShared = 4'hF; snoopDirty = 4'hF;
    snoopValue  = {4{32'hDEAD}};
    step(); // BCAST
    n_checks++;
    if ({busValid, busOp, busProc_ID, busAddress} !== {1'b1, 2'd3, 2'd1, 32'h10}) begin
      n_fail++; $display("FAIL wrbk_bcast: valid=%b op=%0d id=%0d addr=%h want 1/3/1/10", busValid, busOp, busProc_ID, busAddress);
    end
    step(); // MEM
    n_checks++;
    if ({memReq, memWe, memAddress, memWData} !== {1'b1, 1'b1, 32'h10, 32'h7}) begin
      n_fail++; $display("FAIL wrbk_mem: req=%b we=%b addr=%h wdata=%h want 1/1/10/7", memReq, memWe, memAddress, memWData);
    end
    memAck = 1'b1; memRData = 32'h9;
    step(); // RESP at cycle 3
    memAck = 1'b0; reqWrBk = '0; reqRdMs = '0;
    n_checks++;
    if ({respValid, respValue, respShared, respProc_ID} !== {1'b1, 32'h0, 1'b0, 2'd1}) begin
      n_fail++; $display("FAIL wrbk_resp: valid=%b value=%h shared=%b id=%0d want 1/0/0/1", respValid, respValue, respShared, respProc_ID);
    end
    step();
    clear_inputs();
  endtask

  task automatic test_fairness();
    logic [1:0] exp_ids [5];
    exp_ids = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    reqRdMs = 4'hF;
    for (int p = 0; p < NP; p++) reqAddress[p*ADDR_W +: ADDR_W] = 32'h40 + 32'(p);
    for (int k = 0; k < 5; k++) begin
      step(); // BCAST
      n_checks++;
      if (busValid !== 1'b1 || busProc_ID !== exp_ids[k] || grant !== (4'b0001 << exp_ids[k])) begin
        n_fail++; $display("FAIL fair_grant[%0d]: valid=%b id=%0d grant=%b want id %0d", k, busValid, busProc_ID, grant, exp_ids[k]);
      end
      step(); // SNOOP
      step(); // MEM
      memAck = 1'b1; memRData = 32'h100 + 32'(k);
      step(); // RESP
      memAck = 1'b0;
      n_checks++;
      if (respValid !== 1'b1 || respProc_ID !== exp_ids[k] || respValue !== 32'h100 + 32'(k)) begin
        n_fail++; $display("FAIL fair_resp[%0d]: valid=%b id=%0d value=%h want id %0d", k, respValid, respProc_ID, respValue, exp_ids[k]);
      end
      step(); // IDLE gap before next BCAST
      n_checks++;
      if (busValid !== 1'b0 || grant !== 4'b0000) begin
        n_fail++; $display("FAIL fair_gap[%0d]: busValid=%b grant=%b want 0/0000", k, busValid, grant);
      end
    end
    clear_inputs();
    step();
  endtask

  task automatic test_stall_and_reset();
    reqRdMs[3] = 1'b1;
    reqAddress[3*ADDR_W +: ADDR_W] = 32'h20;
    step(); // BCAST
    step(); // SNOOP
    step(); // MEM
    for (int c = 0; c < 5; c++) begin
      n_checks++;
      if (memReq !== 1'b1 || respValid !== 1'b0) begin
        n_fail++; $display("FAIL stall_hold[%0d]: memReq=%b respValid=%b want 1/0", c, memReq, respValid);
      end
      step();
    end
    memAck = 1'b1; memRData = 32'h77;
    step(); // RESP
    memAck = 1'b0; reqRdMs = '0;
    n_checks++;
    if (respValid !== 1'b1 || respValue !== 32'h77 || respProc_ID !== 2'd3) begin
      n_fail++; $display("FAIL stall_resp: valid=%b value=%h id=%0d want 1/77/3", respValid, respValue, respProc_ID);
    end
    step(); // IDLE
    reqRdMs[2] = 1'b1;
    reqAddress[2*ADDR_W +: ADDR_W] = 32'h30;
    step(); // BCAST
    step(); // SNOOP
    step(); // MEM
    n_checks++;
    if (memReq !== 1'b1) begin n_fail++; $display("FAIL rst_pre_mem: memReq=%b want 1", memReq); end
    rst_n = 1'b0;
    step();
    n_checks++;
    if (memReq !== 1'b0 || grant !== 4'b0000 || busValid !== 1'b0) begin
      n_fail++; $display("FAIL rst_mid_mem: memReq=%b grant=%b busValid=%b want 0/0000/0", memReq, grant, busValid);
    end
    rst_n = 1'b1;
    reqRdMs = '0;
    memAck = 1'b1; memRData = 32'hBAD;
    for (int c = 0; c < 3; c++) begin
      step();
      n_checks++;
      if (respValid !== 1'b0 || memReq !== 1'b0 || busValid !== 1'b0) begin
        n_fail++; $display("FAIL rst_late_ack[%0d]: respValid=%b memReq=%b busValid=%b want 0/0/0", c, respValid, memReq, busValid);
      end
    end
    clear_inputs();
  endtask

  initial begin
    clear_inputs();
    rst_n = 1'b0;
    test_reset();
    test_clean_rdms();
    test_dirty_intervention();
    test_wrbk();
    test_fairness();
    test_stall_and_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
